// File: rtl/ao_pkg.sv
// rtl/ao_pkg.sv - shared state encoding, vector ROM and step constants for the AND-OR delay sequencer
package ao_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd11;

  // {a,b,c} stimulus walk; alternates the gate output so most steps see a transition
  function automatic logic [2:0] vec_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return 3'b000;
      4'd1:    return 3'b001;
      4'd2:    return 3'b000;
      4'd3:    return 3'b010;
      4'd4:    return 3'b011;
      4'd5:    return 3'b010;
      4'd6:    return 3'b110;
      4'd7:    return 3'b100;
      4'd8:    return 3'b101;
      4'd9:    return 3'b100;
      4'd10:   return 3'b110;
      4'd11:   return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic vec_expect(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for the asynchronous gate-under-test output
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ao_delay_sequencer.sv
// rtl/ao_delay_sequencer.sv - sweeps 12 vectors into an AND-OR gate and measures per-step output latency
module ao_delay_sequencer
  import ao_pkg::*;
#(
  parameter int TIMEOUT  = 200,
  parameter int HOLD_CYC = 8,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          dut_w,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          busy,
  output logic          done,
  output logic [3:0]    step,
  output logic [CW-1:0] lat,
  output logic          lat_valid,
  output logic [CW-1:0] max_lat,
  output logic          err
);

  localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO       = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold_cnt;
  logic          dut_s;
  logic          exp_w;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_w),
    .q     (dut_s)
  );

  assign exp_w = vec_expect(vec_rom(step));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= 4'd0;
      lat       <= '0;
      lat_valid <= 1'b0;
      max_lat   <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      hold_cnt  <= '0;
    end else begin
      lat_valid <= 1'b0;
      // abort outranks everything, including a match landing in the same cycle
      if (abort) begin
        state     <= ST_IDLE;
        {a, b, c} <= 3'b000;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              step    <= 4'd0;
              max_lat <= '0;
              err     <= 1'b0;
              busy    <= 1'b1;
              done    <= 1'b0;
              state   <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            {a, b, c} <= vec_rom(step);
            cnt       <= CW'(1);
            state     <= ST_WAIT;
          end
          ST_WAIT: begin
            // match is tested first so a match on the timeout cycle still counts
            if (dut_s == exp_w) begin
              lat       <= cnt;
              lat_valid <= 1'b1;
              if (cnt > max_lat) max_lat <= cnt;
              hold_cnt  <= '0;
              state     <= ST_HOLD;
            end else if (cnt == TMO) begin
              err       <= 1'b1;
              lat       <= TMO;
              lat_valid <= 1'b1;
              if (TMO > max_lat) max_lat <= TMO;
              {a, b, c} <= 3'b000;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              if (step == LAST_STEP) begin
                {a, b, c} <= 3'b000;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= ST_DONE;
              end else begin
                step  <= step + 4'd1;
                state <= ST_APPLY;
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: begin
            {a, b, c} <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ao_delay_sequencer.sv
// tb/tb_ao_delay_sequencer.sv - randomized and directed self-checking bench for ao_delay_sequencer
module tb_ao_delay_sequencer;

  localparam int TMO = 20;
  localparam int HC  = 8;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          a, b, c, busy, done, lat_valid, err;
  logic [3:0]    step;
  logic [CW-1:0] lat, max_lat;

  // gate under test: AND-OR with a selectable clocked delay, or stuck at 0
  int          gate_dly = 0;
  logic        gate_tie0 = 1'b0;
  logic [31:0] dl = '0;
  logic        f;
  logic [32:0] taps;
  logic        dut_w;

  assign f     = (a & b) | c;
  assign taps  = {dl, f};
  assign dut_w = gate_tie0 ? 1'b0 : taps[gate_dly];

  always @(posedge clk) dl <= {dl[30:0], f};
  always #5 clk = ~clk;

  ao_delay_sequencer #(.TIMEOUT(TMO), .HOLD_CYC(HC), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dut_w     (dut_w),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .step      (step),
    .lat       (lat),
    .lat_valid (lat_valid),
    .max_lat   (max_lat),
    .err       (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [2:0] rom [12] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 3'b010,
                           3'b110, 3'b100, 3'b101, 3'b100, 3'b110, 3'b010};
  int exp_z  [12] = '{1, 3, 3, 1, 3, 3, 3, 3, 3, 3, 3, 3};
  int exp_d4 [12] = '{1, 7, 7, 1, 7, 7, 7, 7, 7, 7, 7, 7};
  int exp_t0 [12] = '{1, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  function automatic int expect_w(input int s);
    logic [2:0] v;
    v = rom[s];
    return int'((v[2] & v[1]) | v[0]);
  endfunction

  // reference: sweep described as "cycles since this step's apply cycle"
  bit         m_active = 0, m_done = 0, m_latv = 0, m_err = 0, m_matched = 0;
  logic [2:0] m_abc = 3'b000;
  int         m_step = 0, m_elapsed = 0, m_hold_left = 0, m_lat = 0, m_max = 0;
  bit         h1 = 0, h2 = 0;
  int         m_log[$];
  int         dut_log[$];

  task automatic m_finish();
    m_active = 0;
    m_done   = 1;
    m_abc    = 3'b000;
  endtask

  initial begin
    bit syn;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_active = 0; m_done = 0; m_latv = 0; m_err = 0; m_matched = 0;
        m_abc = 3'b000; m_step = 0; m_elapsed = 0; m_lat = 0; m_max = 0;
        h1 = 0; h2 = 0;
      end else begin
        // value the comparator sees now was on dut_w two edges ago
        syn = h2;
        h2 = h1;
        h1 = dut_w;
        m_latv = 0;
        if (abort) begin
          m_active = 0;
          m_done   = 0;
          m_abc    = 3'b000;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1; m_done = 0; m_step = 0; m_max = 0; m_err = 0;
            m_elapsed = 0; m_matched = 0;
          end
        end else if (m_elapsed == 0) begin
          m_abc = rom[m_step];
          m_elapsed = 1;
        end else if (!m_matched) begin
          if (int'(syn) == expect_w(m_step)) begin
            m_lat = m_elapsed; m_latv = 1; m_log.push_back(m_lat);
            if (m_lat > m_max) m_max = m_lat;
            m_matched = 1; m_hold_left = HC;
          end else if (m_elapsed == TMO) begin
            m_err = 1; m_lat = TMO; m_latv = 1; m_log.push_back(m_lat);
            if (m_lat > m_max) m_max = m_lat;
            m_finish();
          end else if (m_elapsed < 255) begin
            m_elapsed++;
          end
        end else begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            if (m_step == 11) m_finish();
            else begin
              m_step++; m_elapsed = 0; m_matched = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (lat_valid) dut_log.push_back(int'(lat));
      check("abc", int'({a, b, c}), int'(m_abc));
      check("busy", int'(busy), int'(m_active));
      check("done", int'(done), int'(m_done));
      check("step", int'(step), m_step);
      check("lat_valid", int'(lat_valid), int'(m_latv));
      check("lat", int'(lat), m_lat);
      check("max_lat", int'(max_lat), m_max);
      check("err", int'(err), int'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_reached"}, int'(done), 1);
  endtask

  task automatic wait_step(input int s, input int limit);
    int n = 0;
    while (int'(step) != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("step_reached", int'(step), s);
  endtask

  task automatic check_log(input string nm, input int expv[12], input int n);
    check({nm, "_dut_count"}, dut_log.size(), n);
    check({nm, "_model_count"}, m_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < dut_log.size()) check({nm, "_dut_lat"}, dut_log[i], expv[i]);
      if (i < m_log.size()) check({nm, "_model_lat"}, m_log[i], expv[i]);
    end
  endtask

  task automatic clear_logs();
    dut_log.delete();
    m_log.delete();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_abc"}, int'({a, b, c}), 0);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
    check({nm, "_step"}, int'(step), 0);
    check({nm, "_lat"}, int'(lat), 0);
    check({nm, "_lat_valid"}, int'(lat_valid), 0);
    check({nm, "_max_lat"}, int'(max_lat), 0);
    check({nm, "_err"}, int'(err), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    tick(3);
    check_all_zero("reset");
    @(negedge clk); #1 rst_n = 1'b1;
    tick(5);

    // zero-delay gate, start pulses while busy, then a second identical sweep
    clear_logs();
    pulse_start();
    tick(30);
    pulse_start();
    tick(40);
    pulse_start();
    wait_done("zero", 1000);
    check_log("zero", exp_z, 12);
    check("zero_max_lat", int'(max_lat), 3);
    check("zero_err", int'(err), 0);
    check("zero_abc", int'({a, b, c}), 0);
    tick(10);
    clear_logs();
    pulse_start();
    wait_done("zero2", 1000);
    check_log("zero2", exp_z, 12);
    check("zero2_max_lat", int'(max_lat), 3);

    // four-cycle gate delay
    gate_dly = 4;
    tick(40);
    clear_logs();
    pulse_start();
    wait_done("d4", 1500);
    check_log("d4", exp_d4, 12);
    check("d4_max_lat", int'(max_lat), 7);
    check("d4_err", int'(err), 0);

    // stuck-low gate forces a timeout on step 1
    gate_dly = 0;
    gate_tie0 = 1'b1;
    tick(40);
    clear_logs();
    pulse_start();
    wait_done("tie0", 500);
    check_log("tie0", exp_t0, 2);
    check("tie0_err", int'(err), 1);
    check("tie0_done", int'(done), 1);
    check("tie0_abc", int'({a, b, c}), 0);
    check("tie0_step", int'(step), 1);
    check("tie0_max_lat", int'(max_lat), 20);

    // abort during step 5 wait
    gate_tie0 = 1'b0;
    tick(10);
    pulse_start();
    wait_step(5, 1000);
    @(negedge clk); #1 abort = 1'b1;
    @(negedge clk); #1 abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_abc", int'({a, b, c}), 0);
    check("abort_lat_valid", int'(lat_valid), 0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (lat_valid) pulses++;
    end
    check("abort_no_pulses", pulses, 0);
    clear_logs();
    pulse_start();
    check("restart_step", int'(step), 0);
    check("restart_err", int'(err), 0);
    check("restart_max_lat", int'(max_lat), 0);
    check("restart_busy", int'(busy), 1);
    wait_done("restart", 1000);
    check_log("restart", exp_z, 12);

    // reset during step 7 hold
    tick(5);
    pulse_start();
    wait_step(7, 1000);
    pulses = 0;
    while (!lat_valid && pulses < 50) begin
      @(negedge clk);
      pulses++;
    end
    check("hold7_strobe", int'(lat_valid), 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    tick(3);
    @(negedge clk); #1 rst_n = 1'b1;
    tick(20);
    check_all_zero("post_reset_idle");
    clear_logs();
    pulse_start();
    wait_done("after_reset", 1000);
    check_log("after_reset", exp_z, 12);

    // randomized start/abort/reset traffic and gate delays
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (i % 250 == 0) begin
        gate_dly  = $urandom_range(0, 22);
        gate_tie0 = ($urandom_range(0, 7) == 0);
      end
      start = ($urandom_range(0, 99) < 4);
      abort = ($urandom_range(0, 199) < 1);
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
